// File: rtl/apb_cmd_master.sv
// apb_cmd_master: command FIFO feeding an APB3 master with a single-entry
// response slot. Define APB_TIMEOUT_EN to add the ACCESS watchdog.
module apb_cmd_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic              busy,
  output logic [7:0]        err_count,
  output logic              timeout
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t            state_q, state_d;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              full, empty;
  logic              push, pop;
  logic              done, abort;
  logic              slot_free;
  logic              to_hit;
  logic              head_wr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q, rsp_write_q, rsp_slverr_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [7:0]        err_q;

  assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign cmd_ready = !full && !PRESET;
  assign push      = cmd_valid && cmd_ready;
  assign slot_free = !rsp_valid_q || rsp_ready;

  assign {head_wr, head_addr, head_data} = mem_q[rd_ptr_q];

  // Command FIFO: pointers wrap naturally, occupancy drives full/empty.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)
        cnt_q <= cnt_q + 1'b1;
      else if (!push && pop)
        cnt_q <= cnt_q - 1'b1;
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wcnt_q, wcnt_d;
  logic            timeout_q;

  assign to_hit  = (state_q == S_ACCESS) && !PREADY &&
                   (wcnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;

  // Count consecutive stalled ACCESS cycles; clears on any other cycle.
  always_comb begin
    wcnt_d = '0;
    if (state_q == S_ACCESS && !PREADY && !to_hit)
      wcnt_d = wcnt_q + 1'b1;
  end

  // Watchdog counter and sticky abort flag.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      if (abort)
        timeout_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (TIMEOUT_CYCLES == 0);
  assign to_hit     = 1'b0;
  assign timeout    = 1'b0;
`endif

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next state, FIFO pop and transfer completion.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && slot_free) begin
          pop     = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          done = 1'b1;
          if (!empty && rsp_ready) begin
            pop     = 1'b1;
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (to_hit) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address/data phase registers, loaded as the FIFO head is popped.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (pop) begin
      pwrite_q <= head_wr;
      paddr_q  <= head_addr;
      pwdata_q <= head_wr ? head_data : '0;
    end
  end

  // Single-entry response slot plus saturating error counter.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
      err_q        <= '0;
    end else begin
      if (done || abort) begin
        rsp_valid_q  <= 1'b1;
        rsp_write_q  <= pwrite_q;
        rsp_rdata_q  <= (done && !pwrite_q) ? PRDATA : '0;
        rsp_slverr_q <= abort || PSLVERR;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      if (((done && PSLVERR) || abort) && err_q != 8'hFF)
        err_q <= err_q + 1'b1;
    end
  end

  assign PSEL       = (state_q != S_IDLE);
  assign PENABLE    = (state_q == S_ACCESS);
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;
  assign err_count  = err_q;
  assign busy       = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed bench for apb_cmd_master with a small
// OR-accumulator APB slave model (DATA 0x00, CONTROL 0x04, RESULT 0x08).
module tb_apb_cmd_master;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        busy;
  logic [7:0]  err_count;
  logic        timeout;

  int checks = 0;
  int failures = 0;

  always #5 PCLK = ~PCLK;

  apb_cmd_master dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy), .err_count(err_count), .timeout(timeout)
  );

  // Slave model
  logic [31:0] s_data, s_ctrl, s_res;
  int          ws_cfg = 0;
  int          ws_cnt;
  logic        hang = 1'b0;
  logic        err_cfg = 1'b0;

  assign PREADY  = !hang && (ws_cnt >= ws_cfg);
  assign PSLVERR = err_cfg && PSEL && PENABLE && PREADY;

  always_comb begin
    PRDATA = '0;
    case (PADDR)
      8'h00: PRDATA = s_data;
      8'h04: PRDATA = s_ctrl;
      8'h08: PRDATA = s_res;
      default: PRDATA = '0;
    endcase
  end

  always @(posedge PCLK) begin
    if (PRESET) begin
      s_data <= '0;
      s_ctrl <= '0;
      s_res  <= '0;
      ws_cnt <= 0;
    end else begin
      if (PSEL && PENABLE && !PREADY)
        ws_cnt <= ws_cnt + 1;
      else
        ws_cnt <= 0;
      if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) begin
        case (PADDR)
          8'h00: s_data <= PWDATA;
          8'h04: begin
            s_ctrl <= PWDATA;
            if (PWDATA[0])
              s_res <= s_res | s_data;
          end
          default: ;
        endcase
      end
    end
  end

  // Response and back-to-back monitors
  typedef struct {
    logic        w;
    logic [31:0] d;
    logic        e;
  } rsp_t;

  rsp_t rsp_q[$];
  logic prev_done = 1'b0;
  int   b2b = 0;

  always @(posedge PCLK) begin
    if (!PRESET && rsp_valid && rsp_ready)
      rsp_q.push_back('{rsp_write, rsp_rdata, rsp_slverr});
    prev_done <= PSEL && PENABLE && PREADY;
    if (PSEL && !PENABLE && prev_done)
      b2b <= b2b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic w, input logic [7:0] a,
                      input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int n = 0; n < 200 && !cmd_ready; n++)
      @(negedge PCLK);
    if (!cmd_ready) begin
      chk("push_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      @(posedge PCLK);
      @(negedge PCLK);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic w,
                            input logic [31:0] d, input logic e);
    rsp_t r;
    for (int n = 0; n < 300 && rsp_q.size() == 0; n++)
      @(negedge PCLK);
    if (rsp_q.size() == 0) begin
      chk({tag, "_none"}, 32'(rsp_q.size()), 32'd1);
    end else begin
      r = rsp_q.pop_front();
      chk({tag, "_w"}, 32'(r.w), 32'(w));
      chk({tag, "_d"}, r.d, d);
      chk({tag, "_e"}, 32'(r.e), 32'(e));
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 3000 && (busy || rsp_valid); n++)
      @(negedge PCLK);
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_access(input string tag);
    for (int n = 0; n < 50 && !(PSEL && PENABLE); n++)
      @(negedge PCLK);
    chk(tag, 32'(PSEL && PENABLE), 32'd1);
  endtask

  int b0;
  int acc;

  initial begin
    // Reset state
    repeat (3) @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("cmd_ready_up", 32'(cmd_ready), 32'd1);

    // 1: single read, latency
    push(1'b0, 8'h08, 32'h0);
    chk("t1_psel_e0", 32'(PSEL), 32'd0);
    @(negedge PCLK);
    chk("t1_psel_e1", 32'(PSEL), 32'd1);
    chk("t1_pen_e1", 32'(PENABLE), 32'd0);
    @(negedge PCLK);
    chk("t1_pen_e2", 32'(PENABLE), 32'd1);
    chk("t1_rv_e2", 32'(rsp_valid), 32'd0);
    @(negedge PCLK);
    chk("t1_rv_e3", 32'(rsp_valid), 32'd1);
    chk("t1_rdata", rsp_rdata, 32'h0);
    chk("t1_slverr", 32'(rsp_slverr), 32'd0);
    chk("t1_err", 32'(err_count), 32'd0);
    expect_rsp("t1", 1'b0, 32'h0, 1'b0);

    // 2: back-to-back write, write, read
    b0 = b2b;
    push(1'b1, 8'h00, 32'h0000000C);
    push(1'b1, 8'h04, 32'h00000001);
    push(1'b0, 8'h08, 32'h0);
    expect_rsp("t2a", 1'b1, 32'h0, 1'b0);
    expect_rsp("t2b", 1'b1, 32'h0, 1'b0);
    expect_rsp("t2c", 1'b0, 32'h0000000C, 1'b0);
    chk("t2_b2b", 32'(b2b - b0), 32'd2);
    wait_idle("t2_idle");

    // 3: response back-pressure fills the FIFO
    rsp_ready = 1'b0;
    push(1'b1, 8'h00, 32'h0000000A);
    push(1'b0, 8'h00, 32'h0);
    push(1'b1, 8'h00, 32'h00000005);
    push(1'b0, 8'h00, 32'h0);
    push(1'b0, 8'h08, 32'h0);
    chk("t3_full", 32'(cmd_ready), 32'd0);
    chk("t3_rv", 32'(rsp_valid), 32'd1);
    repeat (5) @(negedge PCLK);
    chk("t3_psel_hold", 32'(PSEL), 32'd0);
    chk("t3_still_full", 32'(cmd_ready), 32'd0);
    chk("t3_no_rsp", 32'(rsp_q.size()), 32'd0);
    rsp_ready = 1'b1;
    expect_rsp("t3a", 1'b1, 32'h0, 1'b0);
    expect_rsp("t3b", 1'b0, 32'h0000000A, 1'b0);
    expect_rsp("t3c", 1'b1, 32'h0, 1'b0);
    expect_rsp("t3d", 1'b0, 32'h00000005, 1'b0);
    expect_rsp("t3e", 1'b0, 32'h0000000C, 1'b0);
    wait_idle("t3_idle");

    // 4: slave errors and counter saturation
    err_cfg = 1'b1;
    push(1'b1, 8'h0C, 32'h12345678);
    push(1'b1, 8'h08, 32'hFFFFFFFF);
    expect_rsp("t4a", 1'b1, 32'h0, 1'b1);
    expect_rsp("t4b", 1'b1, 32'h0, 1'b1);
    chk("t4_err2", 32'(err_count), 32'd2);
    for (int i = 0; i < 300; i++)
      push(1'b1, 8'h0C, 32'(i));
    wait_idle("t4_idle");
    chk("t4_nrsp", 32'(rsp_q.size()), 32'd300);
    chk("t4_err_sat", 32'(err_count), 32'd255);
    rsp_q.delete();
    err_cfg = 1'b0;

    // 5: wait states, then reset mid-ACCESS
    ws_cfg = 3;
    push(1'b0, 8'h00, 32'h0);
    wait_access("t5_access");
    for (int i = 0; i < 4; i++) begin
      chk("t5_paddr", 32'(PADDR), 32'h0);
      chk("t5_pwrite", 32'(PWRITE), 32'd0);
      chk("t5_pen", 32'(PENABLE), 32'd1);
      chk("t5_pready", 32'(PREADY), 32'(i == 3));
      chk("t5_rv_wait", 32'(rsp_valid), 32'd0);
      @(negedge PCLK);
    end
    chk("t5_rv", 32'(rsp_valid), 32'd1);
    expect_rsp("t5", 1'b0, 32'h00000005, 1'b0);
    push(1'b0, 8'h04, 32'h0);
    push(1'b0, 8'h08, 32'h0);
    wait_access("t5_access2");
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("t5_rst_psel", 32'(PSEL), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(cmd_ready), 32'd0);
    chk("t5_rst_err", 32'(err_count), 32'd0);
    PRESET = 1'b0;
    repeat (6) @(negedge PCLK);
    chk("t5_psel_after", 32'(PSEL), 32'd0);
    chk("t5_rv_after", 32'(rsp_valid), 32'd0);
    chk("t5_no_rsp", 32'(rsp_q.size()), 32'd0);
    chk("t5_ready_after", 32'(cmd_ready), 32'd1);
    ws_cfg = 0;

`ifdef APB_TIMEOUT_EN
    // 6: watchdog abort, next command runs normally
    push(1'b1, 8'h00, 32'h00000077);
    expect_rsp("t6w", 1'b1, 32'h0, 1'b0);
    hang = 1'b1;
    push(1'b0, 8'h08, 32'h0);
    push(1'b0, 8'h00, 32'h0);
    wait_access("t6_access");
    acc = 0;
    while (PSEL && PENABLE && acc < 100) begin
      acc++;
      @(negedge PCLK);
    end
    hang = 1'b0;
    chk("t6_wait_cycles", 32'(acc), 32'd16);
    chk("t6_timeout", 32'(timeout), 32'd1);
    chk("t6_err", 32'(err_count), 32'd1);
    expect_rsp("t6_abort", 1'b0, 32'h0, 1'b1);
    expect_rsp("t6_next", 1'b0, 32'h00000077, 1'b0);
    chk("t6_timeout_sticky", 32'(timeout), 32'd1);
`else
    acc = 0;
    chk("timeout_off", 32'(timeout), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
Command-driven APB master that sits directly upstream of the OR-accumulator APB slave (DATA 0x00, CONTROL 0x04, RESULT 0x08).
- Accepts read/write commands over a valid/ready channel and buffers them in a small FIFO.
- Executes each command as one APB3 transfer (SETUP/ACCESS, PREADY wait states).
- Returns one response per command (rdata, slverr) over a valid/ready response channel.
- Keeps a saturating count of slave errors.

Parameters:
ADDR_W, 8, APB address width
DATA_W, 32, APB data width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 16, max consecutive PREADY=0 cycles in ACCESS (used only with APB_TIMEOUT_EN)

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response held
rsp_ready  in  1  response consumed
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_W  PRDATA for reads, 0 for writes
rsp_slverr  out  1  PSLVERR (or timeout) of the completed transfer
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error
busy  out  1  FIFO non-empty or FSM not IDLE
err_count  out  8  completed transfers with slverr=1, saturates at 255
timeout  out  1  sticky, set on watchdog abort

Behaviour:
- Reset, sampled at an edge, while PRESET=1:
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_* and err_count go to 0; busy=0; timeout=0.
  - FIFO is flushed; cmd_ready=0.
  - Reset mid-transfer aborts it immediately: no response and no error count.
- Command push on cmd_valid&&cmd_ready.
  - cmd_ready = !full && !PRESET.
  - No push when full, and no bypass: a command pushed into an empty FIFO is visible to the FSM at the next edge.
- FSM states are IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=0, PENABLE=0.
  - Go to SETUP when the FIFO is non-empty AND the response slot is free (rsp_valid=0, or rsp_valid&&rsp_ready this cycle).
  - On that transition, pop the FIFO head into PADDR/PWRITE/PWDATA.
  - PWDATA=0 for reads.
- SETUP: PSEL=1, PENABLE=0; go unconditionally to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
  - When PREADY=1, the transfer completes:
    - rsp_valid=1 next cycle; rsp_write=PWRITE.
    - rsp_rdata = PRDATA if read, else 0.
    - rsp_slverr = PSLVERR.
    - err_count increments if PSLVERR=1 and err_count<255.
  - After completion, go to SETUP directly (back-to-back, PENABLE drops for one cycle) if the FIFO is non-empty, else to IDLE. The response slot is guaranteed free at that point only if rsp_ready=1; otherwise go to IDLE and wait.
- Latency: cmd accepted at edge E0 → PSEL=1 after E1 → PENABLE=1 after E2 → with zero wait states, rsp_valid=1 after E3.
- Response slot is single-entry:
  - rsp_valid clears on rsp_valid&&rsp_ready.
  - Response fields are stable while rsp_valid=1.
- Simultaneous push and pop on a full FIFO cannot occur (cmd_ready=0). A push and a pop in the same cycle on a non-full FIFO leave the occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH; full/empty are derived from an occupancy counter of width log2(FIFO_DEPTH)+1.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - A counter counts consecutive ACCESS cycles with PREADY=0.
  - On reaching TIMEOUT_CYCLES, the transfer is aborted: PSEL=PENABLE=0 next cycle, FSM goes to IDLE.
  - A response is produced with rsp_slverr=1 and rsp_rdata=0; err_count increments; timeout sets sticky (cleared only by PRESET).
- Undefined: no counter exists, timeout is tied 0, and the master waits indefinitely for PREADY.

Test Plan:
1. Reset, then push read 0x08 with zero-wait slave → PSEL high 1 cycle after accept, PENABLE the next, response rsp_rdata=0x00000000, rsp_slverr=0, err_count=0.
2. Push write 0x00=0x0000000C, write 0x04=0x00000001, read 0x08 back-to-back, rsp_ready=1 → three responses in order, read returns 0x0000000C; no IDLE gap between transfers (SETUP follows ACCESS directly).
3. Push 5 commands with rsp_ready=0 and PREADY=1 → cmd_ready=0 after 4 buffered, only one transfer completes, PSEL stays 0 until rsp_ready=1, then remaining transfers drain in order.
4. Write 0x0C=0x12345678 and write 0x08=0xFFFFFFFF with PSLVERR=1 → both responses rsp_slverr=1, err_count=2; then 300 error writes → err_count holds 255.
5. Slave inserts 3 wait states on a read 0x00 → PADDR/PWRITE stable for all 4 ACCESS cycles, rsp_valid one cycle after PREADY=1; assert PRESET mid-ACCESS on a second transfer → PSEL=0, FIFO empty, no response.
6. With APB_TIMEOUT_EN, PREADY held 0 → abort after exactly 16 wait cycles, rsp_slverr=1, timeout=1, next queued command then executes normally.
